// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: opcode map, FSM states
// and opcode classification helpers.
package calc_pkg;

   typedef logic [4:0] opcode_t;

   // Codes 00000-01111 belong to the ALU; memory codes are handled locally.
   typedef enum logic [4:0] {
      OP_ADD     = 5'b00000,
      OP_SUB     = 5'b00001,
      OP_MUL     = 5'b00010,
      OP_DIV     = 5'b00011,
      OP_POW     = 5'b00100,
      OP_SQRT    = 5'b00101,
      OP_NEG     = 5'b00110,
      OP_ABS     = 5'b00111,
      OP_AND     = 5'b01000,
      OP_OR      = 5'b01001,
      OP_XOR     = 5'b01010,
      OP_MOD     = 5'b01011,
      OP_SHL     = 5'b01100,
      OP_SHR     = 5'b01101,
      OP_E       = 5'b01110,
      OP_PI      = 5'b01111,
      OP_MADD    = 5'b10001,
      OP_MSUB    = 5'b10010,
      OP_MRECALL = 5'b10100,
      OP_MCLEAR  = 5'b11000
   } calc_op_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } calc_state_t;

   function automatic logic is_alu_op(input opcode_t op);
      return ~op[4];
   endfunction

   // Divide and modulo by zero are screened before reaching the ALU.
   function automatic logic is_zero_div(input opcode_t op, input logic b_is_zero);
      return ((op == OP_DIV) || (op == OP_MOD)) && b_is_zero;
   endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Request/response handshake bundle between the requester and calc_sequencer.
interface calc_sequencer_if #(
   parameter int unsigned OPCODE_LENGTH = 5,
   parameter int unsigned NUM_LENGTH    = 9,
   parameter int unsigned RESULT_WIDTH  = 32
);

   logic                           req_valid;
   logic                           req_ready;
   logic [OPCODE_LENGTH-1:0]       req_opcode;
   logic signed [NUM_LENGTH-1:0]   req_a;
   logic signed [NUM_LENGTH-1:0]   req_b;

   logic                           rsp_valid;
   logic                           rsp_ready;
   logic signed [RESULT_WIDTH-1:0] rsp_result;
   logic                           rsp_error;

   modport master (
      output req_valid, req_opcode, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_error
   );

   modport slave (
      input  req_valid, req_opcode, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_error
   );

endinterface

// File: rtl/calc_sequencer.sv
// Single-operation request/response controller for the calculator ALU.
// Issues ALU operations, waits ALU_LATENCY cycles, returns the result; owns
// the memory register and rejects divide/modulo-by-zero and unassigned codes.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int unsigned OPCODE_LENGTH = 5,
   parameter int unsigned NUM_LENGTH    = 9,
   parameter int unsigned RESULT_WIDTH  = 32,
   parameter int unsigned ALU_LATENCY   = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   calc_sequencer_if.slave                bus,
   output logic [OPCODE_LENGTH-1:0]       alu_opcode,
   output logic signed [NUM_LENGTH-1:0]   alu_a,
   output logic signed [NUM_LENGTH-1:0]   alu_b,
   input  logic signed [RESULT_WIDTH-1:0] alu_c,
   output logic signed [RESULT_WIDTH-1:0] mem_value
);

   localparam int unsigned    CNT_W    = $clog2(ALU_LATENCY) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);

   calc_state_t                    state;
   logic [CNT_W-1:0]               cnt;
   logic signed [RESULT_WIDTH-1:0] mem;
   logic signed [RESULT_WIDTH-1:0] a_ext;
   logic signed [RESULT_WIDTH-1:0] mem_add;
   logic signed [RESULT_WIDTH-1:0] mem_sub;

   assign bus.req_ready = (state == IDLE);
   assign mem_value     = mem;

   // Sign-extended operand A and the wrapping memory update candidates.
   always_comb begin
      a_ext   = {{(RESULT_WIDTH-NUM_LENGTH){bus.req_a[NUM_LENGTH-1]}}, bus.req_a};
      mem_add = mem + a_ext;
      mem_sub = mem - a_ext;
   end

   // Control FSM with registered ALU drive, response and memory register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         mem            <= '0;
         alu_opcode     <= '0;
         alu_a          <= '0;
         alu_b          <= '0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_result <= '0;
         bus.rsp_error  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  if (is_alu_op(bus.req_opcode) &&
                      !is_zero_div(bus.req_opcode, bus.req_b == '0)) begin
                     alu_opcode <= bus.req_opcode;
                     alu_a      <= bus.req_a;
                     alu_b      <= bus.req_b;
                     cnt        <= CNT_LOAD;
                     state      <= EXEC;
                  end else begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_error <= 1'b0;
                     state         <= RESP;
                     // Zero-divide screening falls through to the reject path.
                     case (bus.req_opcode)
                        OP_MADD: begin
                           mem            <= mem_add;
                           bus.rsp_result <= mem_add;
                        end
                        OP_MSUB: begin
                           mem            <= mem_sub;
                           bus.rsp_result <= mem_sub;
                        end
                        OP_MRECALL: begin
                           bus.rsp_result <= mem;
                        end
                        OP_MCLEAR: begin
                           mem            <= '0;
                           bus.rsp_result <= '0;
                        end
                        default: begin
                           bus.rsp_result <= '0;
                           bus.rsp_error  <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  bus.rsp_result <= alu_c;
                  bus.rsp_error  <= 1'b0;
                  bus.rsp_valid  <= 1'b1;
                  state          <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: a latency-1 instance checked every cycle against a
// transaction-level model, plus a latency-4 instance with directed checks.
module tb_calc_sequencer;
   import calc_pkg::*;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic rst2 = 1'b1;
   bit   en1  = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   calc_sequencer_if #(.OPCODE_LENGTH(5), .NUM_LENGTH(9), .RESULT_WIDTH(32)) b1 ();
   calc_sequencer_if #(.OPCODE_LENGTH(5), .NUM_LENGTH(9), .RESULT_WIDTH(32)) b2 ();

   logic [4:0]         alu_op1, alu_op2;
   logic signed [8:0]  alu_a1, alu_b1, alu_a2, alu_b2;
   logic signed [31:0] alu_c1, alu_c2, mem1, mem2, p0, p1, p2;

   // Behavioural ALU standing in for the real one.
   function automatic logic signed [31:0] alu_f(input logic [4:0] op,
                                                input logic signed [8:0] a,
                                                input logic signed [8:0] b);
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      case (op)
         5'd0:    return sa + sb;
         5'd1:    return sa - sb;
         5'd2:    return sa * sb;
         5'd3:    return (sb == 0) ? 0 : sa / sb;
         5'd11:   return (sb == 0) ? 0 : sa % sb;
         default: return sa * (int'(op) + 3) - sb;
      endcase
   endfunction

   assign alu_c1 = alu_f(alu_op1, alu_a1, alu_b1);

   // Latency-4 ALU: result only becomes correct three cycles after issue.
   always @(posedge clk) begin
      p0 <= alu_f(alu_op2, alu_a2, alu_b2);
      p1 <= p0;
      p2 <= p1;
   end
   assign alu_c2 = p2;

   calc_sequencer #(.OPCODE_LENGTH(5), .NUM_LENGTH(9), .RESULT_WIDTH(32), .ALU_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .bus(b1),
      .alu_opcode(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1),
      .alu_c(alu_c1), .mem_value(mem1)
   );

   calc_sequencer #(.OPCODE_LENGTH(5), .NUM_LENGTH(9), .RESULT_WIDTH(32), .ALU_LATENCY(4)) dut2 (
      .clk(clk), .rst(rst2), .bus(b2),
      .alu_opcode(alu_op2), .alu_a(alu_a2), .alu_b(alu_b2),
      .alu_c(alu_c2), .mem_value(mem2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t",
                  name, $signed(act), act, $signed(exp), exp, $time);
      end
   endtask

   // Transaction model: busy flag, remaining wait, expected response and memory.
   bit                 m_busy, m_rv, m_err;
   int                 m_delay;
   logic signed [31:0] m_res, m_mem;
   logic [4:0]         m_op;
   logic signed [8:0]  m_a, m_b;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 0; m_rv <= 0; m_err <= 0; m_delay <= 0;
         m_res <= '0; m_mem <= '0; m_op <= '0; m_a <= '0; m_b <= '0;
      end else if (!m_busy) begin
         if (b1.req_valid) begin
            m_busy <= 1;
            if (b1.req_opcode < 5'd16 &&
                !((b1.req_opcode == 5'd3 || b1.req_opcode == 5'd11) && b1.req_b == 0)) begin
               m_op    <= b1.req_opcode;
               m_a     <= b1.req_a;
               m_b     <= b1.req_b;
               m_res   <= alu_f(b1.req_opcode, b1.req_a, b1.req_b);
               m_err   <= 0;
               m_rv    <= 0;
               m_delay <= 1;
            end else begin
               m_rv <= 1;
               case (b1.req_opcode)
                  5'd17: begin m_mem <= m_mem + 32'(b1.req_a); m_res <= m_mem + 32'(b1.req_a); m_err <= 0; end
                  5'd18: begin m_mem <= m_mem - 32'(b1.req_a); m_res <= m_mem - 32'(b1.req_a); m_err <= 0; end
                  5'd20: begin m_res <= m_mem; m_err <= 0; end
                  5'd24: begin m_mem <= '0; m_res <= '0; m_err <= 0; end
                  default: begin m_res <= '0; m_err <= 1; end
               endcase
            end
         end
      end else if (!m_rv) begin
         if (m_delay == 1) m_rv <= 1;
         m_delay <= m_delay - 1;
      end else if (b1.rsp_ready) begin
         m_rv   <= 0;
         m_busy <= 0;
      end
   end

   // Every-cycle comparison of the latency-1 instance against the model.
   always @(negedge clk) begin
      if (en1 && !rst) begin
         chk("req_ready", 32'(b1.req_ready), 32'(!m_busy));
         chk("rsp_valid", 32'(b1.rsp_valid), 32'(m_rv));
         chk("mem_value", mem1, m_mem);
         chk("alu_opcode", 32'(alu_op1), 32'(m_op));
         chk("alu_a", 32'(alu_a1), 32'(m_a));
         chk("alu_b", 32'(alu_b1), 32'(m_b));
         if (m_rv) begin
            chk("rsp_result", b1.rsp_result, m_res);
            chk("rsp_error", 32'(b1.rsp_error), 32'(m_err));
         end
      end
   end

   task automatic send(input logic [4:0] op, input int a, input int b);
      int n = 0;
      b1.req_valid = 1; b1.req_opcode = op; b1.req_a = 9'(a); b1.req_b = 9'(b);
      while (!b1.req_ready && n < 40) begin @(negedge clk); n++; end
      chk("send_wait", 32'(n < 40), 32'd1);
      @(posedge clk);
   endtask

   task automatic recv(output logic [31:0] res, output logic err, output int lat);
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) b1.req_valid = 0;
         if (b1.rsp_valid) break;
      end
      chk("rsp_wait", 32'(b1.rsp_valid), 32'd1);
      res = b1.rsp_result;
      err = b1.rsp_error;
   endtask

   task automatic txn(input string name, input logic [4:0] op, input int a, input int b,
                      input int exp_res, input logic exp_err, input int exp_lat);
      logic [31:0] res;
      logic        err;
      int          lat;
      send(op, a, b);
      recv(res, err, lat);
      chk({name, "_result"}, res, 32'(exp_res));
      chk({name, "_error"}, 32'(err), 32'(exp_err));
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic send2(input logic [4:0] op, input int a, input int b);
      int n = 0;
      b2.req_valid = 1; b2.req_opcode = op; b2.req_a = 9'(a); b2.req_b = 9'(b);
      while (!b2.req_ready && n < 40) begin @(negedge clk); n++; end
      chk("send2_wait", 32'(n < 40), 32'd1);
      @(posedge clk);
   endtask

   task automatic recv2(output logic [31:0] res, output int lat);
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) b2.req_valid = 0;
         if (b2.rsp_valid) break;
      end
      chk("rsp2_wait", 32'(b2.rsp_valid), 32'd1);
      res = b2.rsp_result;
   endtask

   initial begin
      logic [31:0] res;
      logic        err;
      int          lat;
      int          hits;
      bit          prev_rdy;
      int          r;

      b1.req_valid = 0; b1.req_opcode = '0; b1.req_a = '0; b1.req_b = '0; b1.rsp_ready = 1;
      b2.req_valid = 0; b2.req_opcode = '0; b2.req_a = '0; b2.req_b = '0; b2.rsp_ready = 1;
      repeat (2) @(negedge clk);
      rst  = 0;
      rst2 = 0;
      en1  = 1;
      @(negedge clk);
      chk("reset_req_ready", 32'(b1.req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(b1.rsp_valid), 32'd0);
      chk("reset_rsp_result", b1.rsp_result, 32'd0);
      chk("reset_mem", mem1, 32'd0);
      chk("reset_alu_opcode", 32'(alu_op1), 32'd0);

      txn("add", OP_ADD, 5, -3, 2, 0, 2);
      chk("add_alu_opcode_held", 32'(alu_op1), 32'd0);
      txn("div0", OP_DIV, 7, 0, 0, 1, 1);
      chk("div0_alu_opcode_kept", 32'(alu_op1), 32'd0);
      chk("div0_alu_a_kept", 32'(alu_a1), 32'd5);
      chk("div0_alu_b_kept", 32'(alu_b1), 32'(-3));
      txn("div", OP_DIV, -8, 2, -4, 0, 2);

      txn("mc", OP_MCLEAR, 0, 0, 0, 0, 1);
      txn("mplus100", OP_MADD, 100, 0, 100, 0, 1);
      txn("mplus50", OP_MADD, 50, 0, 150, 0, 1);
      txn("mminus", OP_MSUB, -30, 0, 180, 0, 1);
      txn("mr", OP_MRECALL, 0, 0, 180, 0, 1);
      chk("mem_after_seq", mem1, 32'd180);
      txn("unassigned", 5'b10000, 3, 3, 0, 1, 1);
      chk("mem_after_unassigned", mem1, 32'd180);

      // Backpressure with a competing request held throughout.
      @(negedge clk);
      b1.rsp_ready = 0;
      send(OP_SUB, 10, 4);
      recv(res, err, lat);
      chk("bp_result", res, 32'd6);
      b1.req_valid = 1; b1.req_opcode = OP_ADD; b1.req_a = 9'sd1; b1.req_b = 9'sd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(b1.rsp_valid), 32'd1);
         chk("bp_hold_result", b1.rsp_result, 32'd6);
         chk("bp_ready_low", 32'(b1.req_ready), 32'd0);
      end
      b1.rsp_ready = 1;
      @(negedge clk);
      chk("bp_ready_after_hs", 32'(b1.req_ready), 32'd1);
      chk("bp_valid_dropped", 32'(b1.rsp_valid), 32'd0);
      @(posedge clk);
      recv(res, err, lat);
      chk("bp_next_result", res, 32'd2);
      chk("bp_next_latency", 32'(lat), 32'd2);

      // Latency-4 instance: result at accept+5, then reset mid-operation.
      @(negedge clk);
      send2(OP_MADD, 40, 0);
      recv2(res, lat);
      chk("l4_mplus_result", res, 32'd40);
      @(negedge clk);
      send2(OP_MUL, -12, 11);
      recv2(res, lat);
      chk("l4_mul_result", res, 32'(-132));
      chk("l4_mul_latency", 32'(lat), 32'd5);
      chk("l4_mem_before_rst", mem2, 32'd40);
      @(negedge clk);
      send2(OP_MUL, -12, 11);
      @(negedge clk);
      b2.req_valid = 0;
      @(negedge clk);
      #2 rst2 = 1;
      @(negedge clk);
      #2 rst2 = 0;
      @(negedge clk);
      chk("l4_rst_req_ready", 32'(b2.req_ready), 32'd1);
      chk("l4_rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
      chk("l4_rst_mem", mem2, 32'd0);
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (b2.rsp_valid) hits++;
      end
      chk("l4_no_response_after_rst", 32'(hits), 32'd0);

      // Randomised traffic on the latency-1 instance.
      prev_rdy = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (cyc == 1500) #2 rst = 1;
         if (cyc == 1502) #2 rst = 0;
         if (b1.req_valid && prev_rdy) b1.req_valid = 0;
         if (!b1.req_valid && $urandom_range(0, 2) == 0) begin
            r = int'($urandom_range(0, 99));
            b1.req_a = 9'($urandom_range(0, 511));
            b1.req_b = ($urandom_range(0, 7) == 0) ? 9'sd0 : 9'($urandom_range(0, 511));
            if (r < 40) begin
               b1.req_opcode = 5'($urandom_range(0, 15));
            end else if (r < 50) begin
               b1.req_opcode = (r % 2 == 0) ? OP_DIV : OP_MOD;
               b1.req_b = 9'sd0;
            end else if (r < 80) begin
               case ($urandom_range(0, 3))
                  0: b1.req_opcode = OP_MADD;
                  1: b1.req_opcode = OP_MSUB;
                  2: b1.req_opcode = OP_MRECALL;
                  default: b1.req_opcode = OP_MCLEAR;
               endcase
            end else begin
               b1.req_opcode = 5'($urandom_range(16, 31));
            end
            b1.req_valid = 1;
         end
         b1.rsp_ready = ($urandom_range(0, 9) < 7);
         prev_rdy = b1.req_ready;
      end
      @(negedge clk);
      b1.req_valid = 0;
      b1.rsp_ready = 1;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
